max7219_rx: RTL and testbench
=============================

// Module: max7219_rx
// PURPOSE
//  Receive-side model of a MAX7219 daisy chain. Decodes the serial clk/data/load stream
//  produced by the display driver and maintains each device's register file.
//  Used as a sim/FPGA loopback checker for the debug display path, and as a readback
//  source so other logic can recover what the displays show.
//  - Serial inputs are asynchronous to clk and are synchronised internally.
// PARAMETERS
//  DEVICES   2   number of cascaded MAX7219 devices emulated (1..8)
// PORTS
//  clk            in   1            system clock; all state on its rising edge
//  reset_n        in   1            asynchronous, active-low reset
//  spi_clk        in   1            serial clock from driver (async)
//  spi_din        in   1            serial data, MSB first (async)
//  spi_load       in   1            load/CS; rising edge latches frame (async)
//  rd_dev         in   3            device index for readback (0 = nearest driver)
//  rd_digit       in   3            digit index 0..7 (digit register address 1..8)
//  rd_data        out  8            digit register contents; registered, 1-cycle latency
//  decode_mode    out  8*DEVICES    reg 0x9 per device; device d in [8d+7:8d]
//  intensity      out  4*DEVICES    reg 0xA[3:0] per device
//  scan_limit     out  3*DEVICES    reg 0xB[2:0] per device
//  shutdown_n     out  DEVICES      reg 0xC[0] per device (1 = normal operation)
//  display_test   out  DEVICES      reg 0xF[0] per device
//  frame_strobe   out  1            1-cycle pulse after a valid frame commits
//  frame_err      out  1            1-cycle pulse when a frame is rejected for bad length
// BEHAVIOUR
//  Input synchronisation and timing
//  - Each of spi_clk, spi_din, spi_load passes through a 2-FF synchroniser.
//  - Edges are detected on synchronised spi_clk/spi_load against a third registered copy.
//  - Each spi_clk high and low phase must last >= 3 clk cycles; faster input is unsupported.
//  Shift path
//  - Shift register SR, width W=16*DEVICES, with bit counter BC saturating at W+1.
//  - On spi_clk rise while spi_load low: SR <= {SR[W-2:0], din}; BC <= sat(BC+1).
//  - spi_clk rises while spi_load is high are ignored.
//  - Daisy-chain order: the first 16 bits shifted belong to device DEVICES-1.
//  - After W bits: SR[16d+15:16d] is device d's word.
//  - Word format: [11:8] = address, [7:0] = data, [15:12] = don't care.
//  Commit (spi_load rising edge)
//  - BC==W: commit every device word, then pulse frame_strobe on the next cycle.
//  - BC!=W (including 0 and overrun W+1): no register changes; pulse frame_err.
//  - BC is cleared on every spi_load rise. SR is not cleared.
//  - spi_clk rise and spi_load rise in the same synchronised cycle: the shift happens
//    first, and that bit counts toward BC.
//  Address decode per device word
//  - 0x0: no-op.
//  - 0x1..0x8: digit[addr-1] <= data.
//  - 0x9: decode_mode. 0xA: intensity <= data[3:0]. 0xB: scan_limit <= data[2:0].
//  - 0xC: shutdown_n <= data[0]. 0xF: display_test <= data[0].
//  - 0xD, 0xE: ignored.
//  - Writes to different devices in one frame are independent and all take effect together.
//  Readback
//  - rd_data <= digit[rd_dev][rd_digit], updated on every clk.
//  - rd_dev >= DEVICES returns 8'h00.
//  Reset (reset_n low, asynchronous, may occur mid-frame)
//  - SR, BC and synchronisers cleared; a partial frame is discarded.
//  - All digits, decode_mode, intensity, scan_limit, display_test and rd_data = 0.
//  - shutdown_n = 0 (power-up shutdown). frame_strobe = frame_err = 0.
//  - Synchroniser reset value for spi_load is 1, so releasing reset with load high
//    does not produce a spurious edge.
// TESTING (DEVICES=2)
//  1. Shift 0x0C01 then 0x0301, raise load.
//     -> dev1 shutdown_n=1; dev0 digit[2]=0x01; frame_strobe exactly once; no frame_err.
//  2. Shift 0x0A0F,0x0B07 then 0x0155,0x00FF (two frames).
//     -> dev1 intensity=F; dev0 scan_limit=7; dev1 digit0=0x55; dev0 unchanged by 0x00FF.
//  3. Shift 31 bits, raise load -> frame_err pulse, all registers unchanged.
//     Repeat with 33 bits -> same result.
//  4. Assert reset_n low after 20 bits, release, then send a full valid frame.
//     -> partial bits discarded; registers reflect only the new frame.
//  5. Readback sweep of rd_dev 0..2 x rd_digit 0..7 after loading a known pattern.
//     -> correct data 1 cycle later; rd_dev=2 returns 0x00.
//  6. Drive the max7219 driver instance (devices=2) with data_vector=16'h1234 into this block.
//     -> frame_strobe seen; digit registers match the driver's expected encoding.

Source files
------------

// File: rtl/max7219_rx_if.sv
// Bundle between a MAX7219 serial driver / readback consumer and the receive-side model.
// The serial lines are asynchronous to clk. Everything else is in the clk domain.
interface max7219_rx_if #(
  parameter int DEVICES = 2
);
  logic                   spi_clk;
  logic                   spi_din;
  logic                   spi_load;
  logic [2:0]             rd_dev;
  logic [2:0]             rd_digit;
  logic [7:0]             rd_data;
  logic [8*DEVICES-1:0]   decode_mode;
  logic [4*DEVICES-1:0]   intensity;
  logic [3*DEVICES-1:0]   scan_limit;
  logic [DEVICES-1:0]     shutdown_n;
  logic [DEVICES-1:0]     display_test;
  logic                   frame_strobe;
  logic                   frame_err;

  modport master (
    output spi_clk, spi_din, spi_load, rd_dev, rd_digit,
    input  rd_data, decode_mode, intensity, scan_limit, shutdown_n, display_test,
           frame_strobe, frame_err
  );

  modport slave (
    input  spi_clk, spi_din, spi_load, rd_dev, rd_digit,
    output rd_data, decode_mode, intensity, scan_limit, shutdown_n, display_test,
           frame_strobe, frame_err
  );
endinterface

// File: rtl/max7219_rx.sv
// Receive-side MAX7219 daisy-chain model. It decodes the serial clk/data/load stream
// and keeps a register file per device for loopback checking and readback.
module max7219_rx #(
  parameter int DEVICES = 2
) (
  input logic         clk,
  input logic         reset_n,
  max7219_rx_if.slave bus
);
  localparam int W   = 16 * DEVICES;
  localparam int BCW = $clog2(W + 2);

  logic [2:0]           sclk_q, sclk_d;
  logic [1:0]           din_q, din_d;
  logic [2:0]           load_q, load_d;
  logic [W-1:0]         sr_q, sr_d;
  logic [BCW-1:0]       bc_q, bc_d;
  logic [64*DEVICES-1:0] digit_q, digit_d;
  logic [8*DEVICES-1:0] decode_q, decode_d;
  logic [4*DEVICES-1:0] inten_q, inten_d;
  logic [3*DEVICES-1:0] scan_q, scan_d;
  logic [DEVICES-1:0]   shut_q, shut_d;
  logic [DEVICES-1:0]   dtest_q, dtest_d;
  logic [7:0]           rd_data_q, rd_data_d;
  logic                 strobe_q, strobe_d;
  logic                 err_q, err_d;

  logic       clk_rise, load_rise, shift_en, commit_ok;
  logic [3:0] addr;
  logic [7:0] data;

  assign clk_rise  = sclk_q[1] & ~sclk_q[2];
  assign load_rise = load_q[1] & ~load_q[2];
  // A clk rise that lands in the same cycle as the load rise still shifts its bit in.
  assign shift_en  = clk_rise & (~load_q[1] | load_rise);

  always_comb begin
    sclk_d    = {sclk_q[1:0], bus.spi_clk};
    din_d     = {din_q[0], bus.spi_din};
    load_d    = {load_q[1:0], bus.spi_load};
    sr_d      = sr_q;
    bc_d      = bc_q;
    digit_d   = digit_q;
    decode_d  = decode_q;
    inten_d   = inten_q;
    scan_d    = scan_q;
    shut_d    = shut_q;
    dtest_d   = dtest_q;
    rd_data_d = 8'h00;
    addr      = 4'h0;
    data      = 8'h00;

    if (shift_en) begin
      sr_d    = sr_q << 1;
      sr_d[0] = din_q[1];
      if (bc_q != BCW'(W + 1)) bc_d = bc_q + BCW'(1);
    end

    commit_ok = load_rise && (bc_d == BCW'(W));
    strobe_d  = commit_ok;
    err_d     = load_rise && !commit_ok;
    if (load_rise) bc_d = '0;

    if (commit_ok) begin
      for (int d = 0; d < DEVICES; d++) begin
        addr = sr_d[16*d+8 +: 4];
        data = sr_d[16*d +: 8];
        case (addr)
          4'h1, 4'h2, 4'h3, 4'h4,
          4'h5, 4'h6, 4'h7, 4'h8: digit_d[(d*64 + (int'(addr) - 1)*8) +: 8] = data;
          4'h9:    decode_d[8*d +: 8] = data;
          4'hA:    inten_d[4*d +: 4]  = data[3:0];
          4'hB:    scan_d[3*d +: 3]   = data[2:0];
          4'hC:    shut_d[d]          = data[0];
          4'hF:    dtest_d[d]         = data[0];
          default: ;
        endcase
      end
    end

    // Out-of-range device indices fall through to the 8'h00 default.
    for (int d = 0; d < DEVICES; d++) begin
      if (bus.rd_dev == 3'(d)) rd_data_d = digit_q[(d*64 + int'(bus.rd_digit)*8) +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_q    <= '0;
      din_q     <= '0;
      load_q    <= '1;
      sr_q      <= '0;
      bc_q      <= '0;
      digit_q   <= '0;
      decode_q  <= '0;
      inten_q   <= '0;
      scan_q    <= '0;
      shut_q    <= '0;
      dtest_q   <= '0;
      rd_data_q <= '0;
      strobe_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sclk_q    <= sclk_d;
      din_q     <= din_d;
      load_q    <= load_d;
      sr_q      <= sr_d;
      bc_q      <= bc_d;
      digit_q   <= digit_d;
      decode_q  <= decode_d;
      inten_q   <= inten_d;
      scan_q    <= scan_d;
      shut_q    <= shut_d;
      dtest_q   <= dtest_d;
      rd_data_q <= rd_data_d;
      strobe_q  <= strobe_d;
      err_q     <= err_d;
    end
  end

  assign bus.rd_data      = rd_data_q;
  assign bus.decode_mode  = decode_q;
  assign bus.intensity    = inten_q;
  assign bus.scan_limit   = scan_q;
  assign bus.shutdown_n   = shut_q;
  assign bus.display_test = dtest_q;
  assign bus.frame_strobe = strobe_q;
  assign bus.frame_err    = err_q;
endmodule

// File: tb/tb_max7219_rx.sv
// Directed bench for max7219_rx with two devices. Frame outcomes and readback values are
// queued when stimulus is driven and compared when the block produces them.
module tb_max7219_rx;
  localparam int D = 2;

  logic clk = 1'b0;
  logic reset_n;
  int   tests = 0;
  int   fails = 0;

  max7219_rx_if #(.DEVICES(D)) bus ();
  max7219_rx #(.DEVICES(D)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  int         ev_q[$];
  logic [7:0] rd_q[$];

  logic [7:0] m_digit [D][8];
  logic [7:0] m_dec [D];
  logic [3:0] m_int [D];
  logic [2:0] m_scan [D];
  logic       m_shut [D];
  logic       m_dt [D];

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame outcome monitor: 1 = frame_strobe, 2 = frame_err.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && (bus.frame_strobe === 1'b1 || bus.frame_err === 1'b1)) begin
      int got, exp;
      got = bus.frame_strobe ? 1 : 2;
      exp = (ev_q.size() > 0) ? ev_q.pop_front() : 0;
      check("frame_event", 64'(got), 64'(exp));
    end
  end

  task automatic model_reset();
    for (int d = 0; d < D; d++) begin
      for (int k = 0; k < 8; k++) m_digit[d][k] = 8'h00;
      m_dec[d] = 8'h00; m_int[d] = 4'h0; m_scan[d] = 3'h0; m_shut[d] = 1'b0; m_dt[d] = 1'b0;
    end
  endtask

  task automatic model_word(int d, logic [15:0] w);
    logic [3:0] a;
    a = w[11:8];
    if (a >= 4'h1 && a <= 4'h8) m_digit[d][int'(a) - 1] = w[7:0];
    else if (a == 4'h9) m_dec[d]  = w[7:0];
    else if (a == 4'hA) m_int[d]  = w[3:0];
    else if (a == 4'hB) m_scan[d] = w[2:0];
    else if (a == 4'hC) m_shut[d] = w[0];
    else if (a == 4'hF) m_dt[d]   = w[0];
  endtask

  task automatic check_regs(string tag);
    logic [8*D-1:0] e_dec;
    logic [4*D-1:0] e_int;
    logic [3*D-1:0] e_scan;
    logic [D-1:0]   e_shut, e_dt;
    for (int d = 0; d < D; d++) begin
      e_dec[8*d +: 8] = m_dec[d];
      e_int[4*d +: 4] = m_int[d];
      e_scan[3*d +: 3] = m_scan[d];
      e_shut[d] = m_shut[d];
      e_dt[d] = m_dt[d];
    end
    check({tag, ".decode_mode"}, 64'(bus.decode_mode), 64'(e_dec));
    check({tag, ".intensity"}, 64'(bus.intensity), 64'(e_int));
    check({tag, ".scan_limit"}, 64'(bus.scan_limit), 64'(e_scan));
    check({tag, ".shutdown_n"}, 64'(bus.shutdown_n), 64'(e_shut));
    check({tag, ".display_test"}, 64'(bus.display_test), 64'(e_dt));
  endtask

  task automatic rd_check(int dev, int dig);
    bus.rd_dev   = 3'(dev);
    bus.rd_digit = 3'(dig);
    rd_q.push_back((dev < D) ? m_digit[dev][dig] : 8'h00);
    @(posedge clk); #1;
    check($sformatf("rd[%0d][%0d]", dev, dig), 64'(bus.rd_data), 64'(rd_q.pop_front()));
  endtask

  // Each serial phase lasts four system clocks.
  task automatic shift_bits(logic [63:0] b, int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.spi_din = b[i];
      bus.spi_clk = 1'b0; #40;
      bus.spi_clk = 1'b1; #40;
    end
    bus.spi_clk = 1'b0; #40;
  endtask

  task automatic send_frame(logic [15:0] w_dev1, logic [15:0] w_dev0);
    bus.spi_load = 1'b0; #40;
    shift_bits({32'h0, w_dev1, w_dev0}, 32);
    ev_q.push_back(1);
    model_word(1, w_dev1);
    model_word(0, w_dev0);
    bus.spi_load = 1'b1; #200;
  endtask

  task automatic send_bad(int n);
    bus.spi_load = 1'b0; #40;
    shift_bits({$urandom, $urandom}, n);
    ev_q.push_back(2);
    bus.spi_load = 1'b1; #200;
  endtask

  // Driver-side encoding of a 16-bit value: one hex nibble per digit of device 0,
  // least significant nibble on digit 0, no-op word to device 1.
  task automatic drv_show(logic [15:0] v);
    for (int k = 0; k < 4; k++) send_frame(16'h0000, {4'h0, 4'(k + 1), 4'h0, v[4*k +: 4]});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    bus.spi_clk = 1'b0; bus.spi_din = 1'b0; bus.spi_load = 1'b1;
    bus.rd_dev = 3'd0; bus.rd_digit = 3'd0;
    model_reset();
    #53 reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_regs("reset");
    check("reset.rd_data", 64'(bus.rd_data), 64'h0);
    check("reset.strobe", 64'(bus.frame_strobe), 64'h0);
    check("reset.err", 64'(bus.frame_err), 64'h0);

    // 1: shutdown off on dev1, digit write on dev0
    send_frame(16'h0C01, 16'h0301);
    check_regs("t1");
    rd_check(0, 2);
    rd_check(1, 2);

    // 2: two frames, second one's dev0 word is a no-op
    send_frame(16'h0A0F, 16'h0B07);
    send_frame(16'h0155, 16'h00FF);
    check_regs("t2");
    rd_check(1, 0);
    rd_check(0, 0);
    rd_check(0, 2);

    // 3: short and overlong frames are rejected
    send_bad(31);
    check_regs("t3a");
    rd_check(1, 0);
    send_bad(33);
    check_regs("t3b");
    rd_check(0, 2);

    // 4: reset in the middle of a frame, then a clean frame
    bus.spi_load = 1'b0; #40;
    shift_bits(64'hABCDE, 20);
    #3 reset_n = 1'b0;
    #2;
    model_reset();
    check("t4.async_shut", 64'(bus.shutdown_n), 64'h0);
    check("t4.async_rd", 64'(bus.rd_data), 64'h0);
    #40 reset_n = 1'b1;
    #40;
    send_frame(16'h0F01, 16'h0977);
    check_regs("t4");
    rd_check(1, 0);
    rd_check(0, 2);

    // 5: known pattern, full readback sweep including an absent device
    for (int k = 0; k < 8; k++)
      send_frame({4'h0, 4'(k + 1), 8'hA0 + 8'(k)}, {4'h0, 4'(k + 1), 8'h30 + 8'(k)});
    for (int dv = 0; dv < 3; dv++)
      for (int dg = 0; dg < 8; dg++) rd_check(dv, dg);

    // 6: driver-style display of 16'h1234
    drv_show(16'h1234);
    for (int dg = 0; dg < 4; dg++) rd_check(0, dg);
    rd_check(1, 0);
    check_regs("t6");

    repeat (10) @(posedge clk);
    #1;
    check("pending_events", 64'(ev_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
